// File: rtl/alu_exec_unit_pkg.sv
// Shared ALU control codes and execution-unit state encoding.
// Codes match the ALU-control decoder that feeds this unit.
package alu_exec_unit_pkg;

  localparam logic [2:0] ALU_CONTROL_CONSTANT_AND = 3'b000;
  localparam logic [2:0] ALU_CONTROL_CONSTANT_XOR = 3'b001;
  localparam logic [2:0] ALU_CONTROL_CONSTANT_SLL = 3'b010;
  localparam logic [2:0] ALU_CONTROL_CONSTANT_ADD = 3'b011;
  localparam logic [2:0] ALU_CONTROL_CONSTANT_SUB = 3'b100;
  localparam logic [2:0] ALU_CONTROL_CONSTANT_MUL = 3'b101;
  localparam logic [2:0] ALU_CONTROL_CONSTANT_SRA = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_exec_unit_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, LSB first, WIDTH steps.
// done pulses on the final step with product already holding the low WIDTH bits.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] addend;

  assign addend  = mplier[0] ? mcand : '0;
  // product is the accumulator after the current step, so it is final when done pulses
  assign product = acc + addend;
  assign done    = busy && (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      busy   <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (flush) begin
      busy <= 1'b0;
    end else if (start) begin
      cnt    <= '0;
      busy   <= 1'b1;
      mcand  <= op_a;
      mplier <= op_b;
      acc    <= '0;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: single-cycle ADD/SUB/AND/XOR/SLL/SRA, WIDTH+1-cycle iterative MUL,
// result returned over valid/ready; flush aborts and wins over any same-cycle request.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o
);

  state_t             state, state_nxt;
  logic               accept;
  logic               is_mul;
  logic               mul_start;
  logic               mul_done;
  logic [WIDTH-1:0]   mul_product;
  logic               load;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH-1:0]   res_nxt;
  logic [SHAMT_W-1:0] shamt;

  assign shamt     = op_b_i[SHAMT_W-1:0];
  assign is_mul    = (ALUCtrl_i == ALU_CONTROL_CONSTANT_MUL);
  assign ready_o   = (state == ST_IDLE) || ((state == ST_DONE) && ready_i);
  assign accept    = valid_i && ready_o && !flush_i;
  assign mul_start = accept && is_mul;
  assign valid_o   = (state == ST_DONE);

  // MUL never reaches this path; undefined code 111 falls through to ADD
  always_comb begin
    alu_res = op_a_i + op_b_i;
    case (ALUCtrl_i)
      ALU_CONTROL_CONSTANT_AND: alu_res = op_a_i & op_b_i;
      ALU_CONTROL_CONSTANT_XOR: alu_res = op_a_i ^ op_b_i;
      ALU_CONTROL_CONSTANT_SLL: alu_res = op_a_i << shamt;
      ALU_CONTROL_CONSTANT_SUB: alu_res = op_a_i - op_b_i;
      ALU_CONTROL_CONSTANT_SRA: alu_res = WIDTH'($signed(op_a_i) >>> shamt);
      default:                  alu_res = op_a_i + op_b_i;
    endcase
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    res_nxt   = alu_res;
    if (flush_i) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state_nxt = is_mul ? ST_MUL : ST_DONE;
            load      = !is_mul;
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            state_nxt = ST_DONE;
            load      = 1'b1;
            res_nxt   = mul_product;
          end
        end
        ST_DONE: begin
          if (ready_i) begin
            if (accept) begin
              state_nxt = is_mul ? ST_MUL : ST_DONE;
              load      = !is_mul;
            end else begin
              state_nxt = ST_IDLE;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= ST_IDLE;
      result_o <= '0;
      zero_o   <= 1'b1;
    end else begin
      state <= state_nxt;
      if (load) begin
        result_o <= res_nxt;
        zero_o   <= (res_nxt == '0);
      end
    end
  end

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk_i),
    .rst_n   (rst_i),
    .start   (mul_start),
    .flush   (flush_i),
    .op_a    (op_a_i),
    .op_b    (op_b_i),
    .done    (mul_done),
    .product (mul_product)
  );

endmodule
